// File: rtl/bcd_pkg.sv
// Purpose : shared types and constants for the binary-to-BCD / seven-segment display path.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, blank segment code, digit->segment LUT, pow10 helper for parameter checks.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Segment codes are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry 0 sits in the least-significant slot; codes 10..15 show blank.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,  // 15..10
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,         // 9..5
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40          // 4..0
  };

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Purpose : one BCD digit to active-low seven-segment code, with forced blank.
// Latency : combinational.
// Backpressure: none.
// Ports   : digit[3:0] in, blank in (1 = all segments off), seg[6:0] out {g,f,e,d,c,b,a}.
module seven_seg_decoder
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_LUT[digit];

endmodule

// File: rtl/bin_to_bcd_7seg.sv
// Purpose : iterative double-dabble binary-to-BCD converter with per-digit seven-segment outputs.
// Latency : start accepted at edge k, result and done in the cycle after edge k+WIDTH.
// Backpressure: start only honoured in IDLE; requests during SHIFT/DONE are dropped, not queued.
// Ports   : clk, rst_n (sync, active-low), start, bin[WIDTH], blank_lz in;
//           busy, done, bcd[4*DIGITS], hex[7*DIGITS] out (bcd/hex held until next completion).
module bin_to_bcd_7seg
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  // The accumulator must hold the largest input, otherwise digits would be lost.
  if ((WIDTH < 1) || (WIDTH > 16) ||
      (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1))) begin : g_param_err
    $error("bin_to_bcd_7seg: need 1<=WIDTH<=16 and 10**DIGITS > 2**WIDTH-1");
  end

  bcd_state_t           state_q, state_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 blz_q, blz_d;
  logic [AW-1:0]        bcd_q, bcd_d;
  logic [7*DIGITS-1:0]  hex_q, hex_d;

  logic [AW-1:0]        acc_adj;
  logic [AW-1:0]        acc_shift;
  logic [DIGITS-1:0]    blank_w;
  logic [7*DIGITS-1:0]  seg_w;
  logic                 seen;

  // One double-dabble step: correct digits >=5 so the shift carries into the next digit.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[AW-2:0], sr_q[WIDTH-1]};
  end

  // Blank every digit above the most-significant nonzero one; units always shown.
  always_comb begin
    seen    = 1'b0;
    blank_w = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (acc_shift[4*i +: 4] != 4'd0) seen = 1'b1;
      blank_w[i] = blz_q && !seen && (i != 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seven_seg_decoder u_dec (
      .digit (acc_shift[4*g +: 4]),
      .blank (blank_w[g]),
      .seg   (seg_w[7*g +: 7])
    );
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    blz_d   = blz_q;
    bcd_d   = bcd_q;
    hex_d   = hex_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sr_d    = bin;
          acc_d   = '0;
          blz_d   = blank_lz;
          cnt_d   = CW'(WIDTH);
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - CW'(1);
        // Last bit shifted on this edge: publish the finished accumulator.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = acc_shift;
          hex_d   = seg_w;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      blz_q   <= 1'b0;
      bcd_q   <= '0;
      hex_q   <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      blz_q   <= blz_d;
      bcd_q   <= bcd_d;
      hex_q   <= hex_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;
  assign hex  = hex_q;

endmodule

// File: tb/tb_bin_to_bcd_7seg.sv
module tb_bin_to_bcd_7seg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, blz8, busy8, done8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;
  logic [20:0] hex8;
  logic        start12, blz12, busy12, done12;
  logic [11:0] bin12;
  logic [15:0] bcd12;
  logic [27:0] hex12;

  bin_to_bcd_7seg #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin(bin8), .blank_lz(blz8),
    .busy(busy8), .done(done8), .bcd(bcd8), .hex(hex8)
  );

  bin_to_bcd_7seg #(.WIDTH(12), .DIGITS(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .bin(bin12), .blank_lz(blz12),
    .busy(busy12), .done(done12), .bcd(bcd12), .hex(hex12)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic [27:0] hex;
  } exp_t;

  exp_t sb8[$];
  exp_t sb12[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference: decimal digits by division, then blank above the top nonzero digit.
  function automatic exp_t model(input int v, input int nd, input bit blz);
    exp_t r;
    int t, msd, d;
    r = '0; t = v; msd = 0;
    for (int i = 0; i < nd; i++) begin
      d = t % 10; t = t / 10;
      r.bcd[4*i +: 4] = 4'(d);
      if (d != 0) msd = i;
    end
    for (int i = 0; i < nd; i++) begin
      d = int'(r.bcd[4*i +: 4]);
      r.hex[7*i +: 7] = (blz && i > msd) ? 7'h7F : seg_of(d);
    end
    return r;
  endfunction

  // Full conversion on the 8-bit instance, optional ignored start pulses in SHIFT / DONE.
  task automatic run8(input int v, input bit b, input int inj_shift, input bit inj_done,
                      input string tag);
    int n, nb;
    bit ok;
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; bin8 = 8'(v); blz8 = b;
    sb8.push_back(model(v, 3, b));
    @(negedge clk);
    start8 = 1'b0; bin8 = 8'($urandom); blz8 = ~b;
    n = 0; nb = 0;
    while (done8 !== 1'b1 && n < 40) begin
      if (busy8 === 1'b1) nb++;
      start8 = (n == inj_shift);
      if (n == inj_shift) bin8 = 8'd99;
      @(negedge clk);
      n++;
    end
    start8 = 1'b0;
    chk({tag, " latency"}, n, 8);
    chk({tag, " busy_cycles"}, nb, 8);
    chk({tag, " busy_at_done"}, {31'd0, busy8}, 0);
    e = (sb8.size() > 0) ? sb8.pop_front() : '0;
    chk({tag, " bcd"}, {20'd0, bcd8}, {20'd0, e.bcd[11:0]});
    chk({tag, " hex"}, {11'd0, hex8}, {11'd0, e.hex[20:0]});
    if (inj_done) begin
      start8 = 1'b1; bin8 = 8'd99;
      @(negedge clk);
      start8 = 1'b0;
      ok = 1'b1;
      repeat (14) begin
        if (done8 !== 1'b0 || busy8 !== 1'b0) ok = 1'b0;
        @(negedge clk);
      end
      chk({tag, " no_requeue"}, {31'd0, ok}, 1);
      chk({tag, " bcd_held"}, {20'd0, bcd8}, {20'd0, e.bcd[11:0]});
    end
  endtask

  task automatic run12(input int v, input bit b);
    int n;
    exp_t e;
    @(negedge clk);
    start12 = 1'b1; bin12 = 12'(v); blz12 = b;
    sb12.push_back(model(v, 4, b));
    @(negedge clk);
    start12 = 1'b0; bin12 = 12'($urandom);
    n = 0;
    while (done12 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = (sb12.size() > 0) ? sb12.pop_front() : '0;
    chk($sformatf("w12 %0d latency", v), n, 12);
    chk($sformatf("w12 %0d bcd", v), {16'd0, bcd12}, {16'd0, e.bcd});
    chk($sformatf("w12 %0d hex", v), {4'd0, hex12}, {4'd0, e.hex});
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    start8 = 1'b0; bin8 = '0; blz8 = 1'b0;
    start12 = 1'b0; bin12 = '0; blz12 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", {30'd0, busy8, busy12}, 0);
    chk("rst done", {30'd0, done8, done12}, 0);
    chk("rst bcd8", {20'd0, bcd8}, 0);
    chk("rst hex8", {11'd0, hex8}, 32'h1F_FFFF);
    chk("rst bcd12", {16'd0, bcd12}, 0);
    chk("rst hex12", {4'd0, hex12}, 32'hFFF_FFFF);
    rst_n = 1'b1;

    run8(255, 1'b0, -1, 1'b0, "d255");
    chk("d255 hex literal", {11'd0, hex8}, {11'd0, 7'h24, 7'h12, 7'h12});
    chk("d255 bcd literal", {20'd0, bcd8}, 32'h255);
    run8(0, 1'b1, -1, 1'b0, "d0_blank");
    chk("d0_blank hex literal", {11'd0, hex8}, {11'd0, 7'h7F, 7'h7F, 7'h40});
    run8(7, 1'b0, -1, 1'b0, "d7");
    chk("d7 hex literal", {11'd0, hex8}, {11'd0, 7'h40, 7'h40, 7'h78});
    run8(105, 1'b1, -1, 1'b0, "d105_blank");
    chk("d105 hex literal", {11'd0, hex8}, {11'd0, 7'h79, 7'h40, 7'h12});
    run8(200, 1'b0, 2, 1'b1, "d200_ignored_start");
    chk("d200 bcd literal", {20'd0, bcd8}, 32'h200);
    run8(9, 1'b1, -1, 1'b0, "d9_blank");
    run8(90, 1'b1, -1, 1'b0, "d90_blank");

    // Abort a conversion of 255 with reset at edge k+4.
    @(negedge clk);
    start8 = 1'b1; bin8 = 8'd255; blz8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy_before_reset", {31'd0, busy8}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", {31'd0, busy8}, 0);
    chk("abort bcd", {20'd0, bcd8}, 0);
    chk("abort hex", {11'd0, hex8}, 32'h1F_FFFF);
    ok = 1'b1;
    repeat (14) begin
      if (done8 !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk("abort no_done", {31'd0, ok}, 1);
    run8(42, 1'b0, -1, 1'b0, "after_abort");

    for (int v = 0; v <= 4095; v += 3) run12(v, v[0]);
    run12(4094, 1'b1);
    run12(1000, 1'b1);

    chk("sb8 drained", sb8.size(), 0);
    chk("sb12 drained", sb12.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_7seg.md
# bin_to_bcd_7seg

Parametrised, sequential binary-to-BCD converter with per-digit active-low seven-segment outputs. It generalises the fixed 4-bit combinational converter and two-digit display path to any input width and digit count, using an iterative shift-add-3 (double-dabble) datapath. It adds a start/done handshake, registered result hold and optional leading-zero blanking. It sits between switch/counter logic and the board HEX displays.

## Interface
- `WIDTH`, default 8: binary input width, 1..16.
- `DIGITS`, default 3: BCD digits produced. Elaboration fails unless 10^DIGITS > 2^WIDTH − 1.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, **synchronous, active-low**.
- `start`  in  1: request a conversion. Accepted only in IDLE.
- `bin`  in  WIDTH: unsigned value. Sampled on the accepting edge.
- `blank_lz`  in  1: leading-zero blanking enable. Sampled with `bin`.
- `busy`  out  1: high while in SHIFT.
- `done`  out  1: one-cycle pulse; the result is valid in the same cycle.
- `bcd`  out  4·DIGITS: digit i is `bcd[4i+3:4i]`, with i=0 as units. Held until the next completion.
- `hex`  out  7·DIGITS: digit i is `hex[7i+6:7i]` = {g,f,e,d,c,b,a}, active-low. Held until the next completion.

## Operation
- FSM states and transitions:
  - IDLE: on `start`=1, go to SHIFT. Load the shift register with `bin`, clear the BCD accumulator, latch `blank_lz`, and set the counter to WIDTH.
  - SHIFT, each cycle:
    - add 3 to every accumulator digit ≥5;
    - shift {accumulator, shift register} left by one;
    - decrement the counter.
  - SHIFT exits when the counter reaches 1; that edge performs the final shift and goes to DONE.
  - DONE: lasts one cycle, then returns to IDLE unconditionally.
- Output registers `bcd`/`hex` load on the SHIFT→DONE edge only, from the post-final-shift accumulator.
- The accumulator is 4·DIGITS bits. By the parameter rule it cannot overflow, so no overflow flag exists.
- Segment encoding, 0–9: 40,79,24,30,19,12,02,78,00,10 (hex). Codes 10–15 map to 7F (blank), which is unreachable in normal operation.
- Leading-zero blanking, when latched `blank_lz`=1:
  - every digit above the most-significant nonzero digit shows 7F;
  - digit 0 is never blanked.
  - `bcd` is unaffected by blanking.
- `start` in SHIFT or DONE is ignored; it is not queued. `bin` changes after the accepting edge have no effect.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state IDLE, `busy`=0, `done`=0;
  - `bcd`=0;
  - every `hex` digit 7F (all segments off).
- Reset mid-SHIFT aborts the conversion. Outputs still take the reset values and no `done` is produced. Reset has priority over `start` on the same edge.
- Latency: `start` accepted at edge k → `busy`=1 for cycles k..k+WIDTH−1 → `bcd`/`hex` update and `done`=1 in the cycle after edge k+WIDTH.
- Throughput: one conversion per WIDTH+2 cycles. The earliest next accept is the edge ending the cycle after `done`.
- `busy` and `done` are never high together.

## Structure
- Package `bcd_pkg` contains:
  - the state enum `bcd_state_t` {IDLE, SHIFT, DONE};
  - `SEG_BLANK` = 7'h7F;
  - the 16-entry segment LUT constant `SEG_LUT`.
- Sub-module `seven_seg_decoder`: combinational, 4-bit digit plus blank input → 7-bit active-low segments. It is instantiated DIGITS times via generate on the final accumulator value.
- Blank-mask computation, the FSM and the datapath stay in the top module.

## Test plan
- WIDTH=8, DIGITS=3, `bin`=255, `blank_lz`=0, `start` pulsed at edge k → `busy` high for 8 cycles; `done` in the cycle after edge k+8; `bcd`=12'h255; `hex` = {24,12,12}.
- `bin`=0, `blank_lz`=1 → `bcd`=0; `hex[20:7]` = {7F,7F}; `hex[6:0]`=40. Then `bin`=7, `blank_lz`=0 → `hex` = {40,40,78}.
- `bin`=105, `blank_lz`=1 → `bcd`=12'h105. The inner zero is not blanked: `hex` = {79,40,12}.
- Conversion of 200 started; `start` with `bin`=99 pulsed at cycles k+3 and k+9 (DONE) → both ignored; the result is 12'h200; no second `done`.
- `rst_n`=0 at edge k+4 of a conversion of 255 → `busy`=0, `bcd`=0, all `hex`=7F, and no `done` pulse. A subsequent `start` converts normally.
- WIDTH=12, DIGITS=4 sweep of 0..4095 against a reference model → `bcd` correct, latency always 12.
